// File: rtl/result_writeback_stager.sv
// Result writeback stager: delays execution-unit results by their declared
// latency, issues register-file writes and forwards in-flight results.
module result_writeback_stager #(
    parameter int DEPTH = 7,
    parameter int AW    = 7,
    parameter int DW    = 128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [0:DW+AW+3]   in_packet,
    input  logic [0:AW-1]      lookup_a_addr,
    input  logic [0:AW-1]      lookup_b_addr,
    output logic               rf_we,
    output logic [0:AW-1]      rf_addr,
    output logic [0:DW-1]      rf_data,
    output logic               fwd_a_hit,
    output logic [0:DW-1]      fwd_a_data,
    output logic               fwd_b_hit,
    output logic [0:DW-1]      fwd_b_data,
    output logic               collision_err
);

    localparam logic [2:0] AGE_MAX = 3'(DEPTH - 1);

    logic          vld_q  [1:DEPTH];
    logic          vld_d  [1:DEPTH];
    logic [AW-1:0] rt_q   [1:DEPTH];
    logic [AW-1:0] rt_d   [1:DEPTH];
    logic [DW-1:0] data_q [1:DEPTH];
    logic [DW-1:0] data_d [1:DEPTH];
    logic [2:0]    age_q  [1:DEPTH];
    logic [2:0]    age_d  [1:DEPTH];
    logic          err_q;
    logic          err_d;

    logic [DW-1:0] pkt_data;
    logic [2:0]    pkt_lat;
    logic          pkt_wr;
    logic [AW-1:0] pkt_rt;
    logic [AW-1:0] la;
    logic [AW-1:0] lb;

    assign pkt_data = in_packet[0:DW-1];
    assign pkt_lat  = in_packet[DW:DW+2];
    assign pkt_wr   = in_packet[DW+3];
    assign pkt_rt   = in_packet[DW+4:DW+AW+3];
    assign la       = lookup_a_addr;
    assign lb       = lookup_b_addr;

    int le;
    int k;

    always_comb begin
        le = int'(pkt_lat);
        if (le == 0)
            le = 1;
        else if (le > DEPTH)
            le = DEPTH;
        k = DEPTH - le + 1;
    end

    always_comb begin
        err_d     = err_q;
        vld_d[1]  = 1'b0;
        rt_d[1]   = '0;
        data_d[1] = '0;
        age_d[1]  = '0;
        for (int i = 2; i <= DEPTH; i++) begin
            vld_d[i]  = vld_q[i-1];
            rt_d[i]   = rt_q[i-1];
            data_d[i] = data_q[i-1];
            age_d[i]  = age_q[i-1];
            if (vld_q[i-1] && age_q[i-1] != AGE_MAX)
                age_d[i] = age_q[i-1] + 3'd1;
        end
        // An occupied target slot keeps the older result; the new one is lost.
        for (int i = 1; i <= DEPTH; i++) begin
            if (pkt_wr && i == k) begin
                if (vld_d[i]) begin
                    err_d = 1'b1;
                end else begin
                    vld_d[i]  = 1'b1;
                    rt_d[i]   = pkt_rt;
                    data_d[i] = pkt_data;
                    age_d[i]  = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
            for (int i = 1; i <= DEPTH; i++) begin
                vld_q[i]  <= 1'b0;
                rt_q[i]   <= '0;
                data_q[i] <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            err_q <= err_d;
            for (int i = 1; i <= DEPTH; i++) begin
                vld_q[i]  <= vld_d[i];
                rt_q[i]   <= rt_d[i];
                data_q[i] <= data_d[i];
                age_q[i]  <= age_d[i];
            end
        end
    end

    assign rf_we         = vld_q[DEPTH];
    assign rf_addr       = rt_q[DEPTH];
    assign rf_data       = data_q[DEPTH];
    assign collision_err = err_q;

    logic          a_hit;
    logic          b_hit;
    logic [DW-1:0] a_data;
    logic [DW-1:0] b_data;
    logic [3:0]    a_age;
    logic [3:0]    b_age;

    // Youngest match wins; ages are unique, so no tie-break is needed.
    always_comb begin
        a_hit  = 1'b0;
        a_data = '0;
        a_age  = 4'hF;
        b_hit  = 1'b0;
        b_data = '0;
        b_age  = 4'hF;
        for (int i = 1; i <= DEPTH; i++) begin
            if (vld_q[i] && rt_q[i] == la && {1'b0, age_q[i]} < a_age) begin
                a_hit  = 1'b1;
                a_data = data_q[i];
                a_age  = {1'b0, age_q[i]};
            end
            if (vld_q[i] && rt_q[i] == lb && {1'b0, age_q[i]} < b_age) begin
                b_hit  = 1'b1;
                b_data = data_q[i];
                b_age  = {1'b0, age_q[i]};
            end
        end
    end

    assign fwd_a_hit  = a_hit;
    assign fwd_a_data = a_data;
    assign fwd_b_hit  = b_hit;
    assign fwd_b_data = b_data;

endmodule

// File: tb/tb_result_writeback_stager.sv
// Directed bench for result_writeback_stager: latency table plus
// hand-written reset, collision, forwarding and throughput sequences.
module tb_result_writeback_stager;

    logic         clk;
    logic         reset;
    logic [0:138] in_packet;
    logic [0:6]   lookup_a_addr;
    logic [0:6]   lookup_b_addr;
    logic         rf_we;
    logic [0:6]   rf_addr;
    logic [0:127] rf_data;
    logic         fwd_a_hit;
    logic [0:127] fwd_a_data;
    logic         fwd_b_hit;
    logic [0:127] fwd_b_data;
    logic         collision_err;

    int errors = 0;
    int checks = 0;

    result_writeback_stager dut (
        .clk           (clk),
        .reset         (reset),
        .in_packet     (in_packet),
        .lookup_a_addr (lookup_a_addr),
        .lookup_b_addr (lookup_b_addr),
        .rf_we         (rf_we),
        .rf_addr       (rf_addr),
        .rf_data       (rf_data),
        .fwd_a_hit     (fwd_a_hit),
        .fwd_a_data    (fwd_a_data),
        .fwd_b_hit     (fwd_b_hit),
        .fwd_b_data    (fwd_b_data),
        .collision_err (collision_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         wr;
        logic [2:0]   lat;
        logic [6:0]   rt;
        logic [127:0] data;
        logic         exp_we;
        logic [6:0]   exp_addr;
        logic [127:0] exp_data;
    } vec_t;

    function automatic logic [138:0] pk(input logic wr, input logic [2:0] l,
                                        input logic [6:0] rt,
                                        input logic [127:0] d);
        return {d, l, wr, rt};
    endfunction

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_packet = pk(1'b0, 3'd0, 7'd0, 128'd0);
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    vec_t tbl[14];

    initial begin
        reset         = 1'b0;
        lookup_a_addr = 7'd0;
        lookup_b_addr = 7'd0;
        idle();

        // Latency sweep: L=1..7, then L=0, then a wr=0 packet, then drain.
        tbl[0]  = '{1, 3'd1, 7'd1, 128'h10, 1, 7'd1, 128'h10};
        tbl[1]  = '{1, 3'd2, 7'd2, 128'h20, 0, 7'd0, 128'h0};
        tbl[2]  = '{1, 3'd3, 7'd3, 128'h30, 1, 7'd2, 128'h20};
        tbl[3]  = '{1, 3'd4, 7'd4, 128'h40, 0, 7'd0, 128'h0};
        tbl[4]  = '{1, 3'd5, 7'd5, 128'h50, 1, 7'd3, 128'h30};
        tbl[5]  = '{1, 3'd6, 7'd6, 128'h60, 0, 7'd0, 128'h0};
        tbl[6]  = '{1, 3'd7, 7'd7, 128'h70, 1, 7'd4, 128'h40};
        tbl[7]  = '{1, 3'd0, 7'd8, 128'h80, 1, 7'd8, 128'h80};
        tbl[8]  = '{0, 3'd1, 7'd9, 128'hFF, 1, 7'd5, 128'h50};
        tbl[9]  = '{0, 3'd0, 7'd0, 128'h0,  0, 7'd0, 128'h0};
        tbl[10] = '{0, 3'd0, 7'd0, 128'h0,  1, 7'd6, 128'h60};
        tbl[11] = '{0, 3'd0, 7'd0, 128'h0,  0, 7'd0, 128'h0};
        tbl[12] = '{0, 3'd0, 7'd0, 128'h0,  1, 7'd7, 128'h70};
        tbl[13] = '{0, 3'd0, 7'd0, 128'h0,  0, 7'd0, 128'h0};

        // Reset sequencing
        tick();
        tick();
        chk("rst_we", rf_we, 0);
        chk("rst_addr", rf_addr, 0);
        chk("rst_data", rf_data, 0);
        chk("rst_ahit", fwd_a_hit, 0);
        chk("rst_adata", fwd_a_data, 0);
        chk("rst_bhit", fwd_b_hit, 0);
        chk("rst_bdata", fwd_b_data, 0);
        chk("rst_err", collision_err, 0);
        reset = 1'b1;
        in_packet = pk(1'b1, 3'd1, 7'd5, 128'h1);
        tick();
        idle();
        chk("first_we", rf_we, 1);
        chk("first_addr", rf_addr, 5);
        chk("first_data", rf_data, 1);
        tick();
        chk("first_we_drop", rf_we, 0);

        // Latency sweep table
        for (int i = 0; i < 14; i++) begin
            in_packet = pk(tbl[i].wr, tbl[i].lat, tbl[i].rt, tbl[i].data);
            tick();
            chk($sformatf("sweep%0d_we", i), rf_we, tbl[i].exp_we);
            if (tbl[i].exp_we) begin
                chk($sformatf("sweep%0d_addr", i), rf_addr, tbl[i].exp_addr);
                chk($sformatf("sweep%0d_data", i), rf_data, tbl[i].exp_data);
            end
            chk($sformatf("sweep%0d_err", i), collision_err, 0);
        end
        idle();

        // Collision
        in_packet = pk(1'b1, 3'd3, 7'd9, 128'h99);
        tick();
        chk("col_c0_we", rf_we, 0);
        chk("col_c0_err", collision_err, 0);
        in_packet = pk(1'b1, 3'd2, 7'd10, 128'hAA);
        tick();
        idle();
        chk("col_c1_we", rf_we, 0);
        chk("col_c1_err", collision_err, 1);
        tick();
        chk("col_ret_we", rf_we, 1);
        chk("col_ret_addr", rf_addr, 9);
        chk("col_ret_data", rf_data, 128'h99);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("col_after%0d_we", i), rf_we, 0);
            chk($sformatf("col_after%0d_err", i), collision_err, 1);
        end
        do_reset();
        chk("col_err_cleared", collision_err, 0);

        // Forwarding priority
        lookup_a_addr = 7'd20;
        lookup_b_addr = 7'd21;
        in_packet = pk(1'b1, 3'd7, 7'd20, 128'hA);
        tick();
        idle();
        chk("fwd_e0_hit", fwd_a_hit, 1);
        chk("fwd_e0_data", fwd_a_data, 128'hA);
        tick();
        chk("fwd_e1_data", fwd_a_data, 128'hA);
        in_packet = pk(1'b1, 3'd4, 7'd20, 128'hB);
        tick();
        idle();
        chk("fwd_e2_hit", fwd_a_hit, 1);
        chk("fwd_e2_data", fwd_a_data, 128'hB);
        chk("fwd_e2_bhit", fwd_b_hit, 0);
        chk("fwd_e2_bdata", fwd_b_data, 0);
        tick();
        chk("fwd_e3_data", fwd_a_data, 128'hB);
        tick();
        chk("fwd_e4_data", fwd_a_data, 128'hB);
        tick();
        chk("fwd_e5_we", rf_we, 1);
        chk("fwd_e5_rdata", rf_data, 128'hB);
        chk("fwd_e5_data", fwd_a_data, 128'hB);
        tick();
        chk("fwd_e6_we", rf_we, 1);
        chk("fwd_e6_rdata", rf_data, 128'hA);
        chk("fwd_e6_data", fwd_a_data, 128'hA);
        chk("fwd_e6_bhit", fwd_b_hit, 0);
        tick();
        chk("fwd_e7_hit", fwd_a_hit, 0);
        chk("fwd_e7_data", fwd_a_data, 0);
        do_reset();

        // Mid-flight reset
        lookup_a_addr = 7'd31;
        for (int i = 0; i < 3; i++) begin
            in_packet = pk(1'b1, 3'd6, 7'(30 + i), 128'(i + 1));
            tick();
        end
        idle();
        chk("mid_hit_pre", fwd_a_hit, 1);
        tick();
        tick();
        tick();
        chk("mid_we_pre", rf_we, 1);
        chk("mid_addr_pre", rf_addr, 30);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_we_async", rf_we, 0);
        chk("mid_hit_async", fwd_a_hit, 0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("mid_post%0d_we", i), rf_we, 0);
        end

        // Back-to-back throughput
        for (int i = 0; i < 10; i++) begin
            in_packet = pk(1'b1, 3'd1, 7'(i), 128'(16'h100 + i));
            tick();
            chk($sformatf("b2b%0d_we", i), rf_we, 1);
            chk($sformatf("b2b%0d_addr", i), rf_addr, 128'(i));
            chk($sformatf("b2b%0d_data", i), rf_data, 128'(16'h100 + i));
            chk($sformatf("b2b%0d_err", i), collision_err, 0);
        end
        idle();
        tick();
        chk("b2b_end_we", rf_we, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
